// File: rtl/seg_display_scan.sv
// seg_display_scan
// Multiplexed 4-digit seven-segment driver for the CPU observer debug word.
// Each digit is lit for SCAN_DIV clock cycles. A 16-bit snapshot of data_i
// (and mode_i) is taken at every frame boundary, on the digit 3 -> 0 wrap,
// so one scan pass never mixes two values.
//
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   en_i     display enable; 0 blanks outputs and freezes the scan
//   data_i   observer data word, captured at each frame boundary
//   mode_i   observer mode; shown on the decimal points
//   an_o     digit enables, an_o[0] = rightmost digit
//   seg_o    segments {g,f,e,d,c,b,a}
//   dp_o     decimal point
//   frame_o  one-cycle pulse on each snapshot load
module seg_display_scan #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter bit          AN_ACTIVE_LOW  = 1'b1,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic [15:0] data_i,
  input  logic [2:0]  mode_i,
  output logic [3:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic        frame_o
);

  localparam int unsigned CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  // Output levels for "everything dark" under the chosen polarities.
  localparam logic [3:0] AN_OFF  = AN_ACTIVE_LOW  ? 4'hF : 4'h0;
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = SEG_ACTIVE_LOW;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       dig_q, dig_d;
  logic [15:0]      shadow_q, shadow_d;
  logic [2:0]       mode_sh_q, mode_sh_d;
  logic             frame_q, frame_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic       tick;
  logic       wrap;
  logic [3:0] nibble;
  logic [6:0] seg_hi;
  logic [3:0] an_hot;
  logic       dp_hi;

  // Scan state: divider, digit index and frame snapshot.
  always_comb begin
    tick      = en_i && (cnt_q == CNT_LAST);
    wrap      = tick && (dig_q == 2'd3);
    cnt_d     = cnt_q;
    dig_d     = dig_q;
    shadow_d  = shadow_q;
    mode_sh_d = mode_sh_q;
    frame_d   = 1'b0;
    if (en_i) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
    if (tick) begin
      dig_d = dig_q + 2'd1;
    end
    if (wrap) begin
      shadow_d  = data_i;
      mode_sh_d = mode_i;
      frame_d   = 1'b1;
    end
  end

  // The display registers are decoded from the next-state values, so the
  // cycle that raises frame_o is also the first cycle showing the new
  // snapshot on digit 0, and each digit change appears with its tick.
  always_comb begin
    nibble = shadow_d[{dig_d, 2'b00} +: 4];
    unique case (nibble)
      4'h0: seg_hi = 7'h3F;
      4'h1: seg_hi = 7'h06;
      4'h2: seg_hi = 7'h5B;
      4'h3: seg_hi = 7'h4F;
      4'h4: seg_hi = 7'h66;
      4'h5: seg_hi = 7'h6D;
      4'h6: seg_hi = 7'h7D;
      4'h7: seg_hi = 7'h07;
      4'h8: seg_hi = 7'h7F;
      4'h9: seg_hi = 7'h6F;
      4'hA: seg_hi = 7'h77;
      4'hB: seg_hi = 7'h7C;
      4'hC: seg_hi = 7'h39;
      4'hD: seg_hi = 7'h5E;
      4'hE: seg_hi = 7'h79;
      default: seg_hi = 7'h71;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_an
      assign an_hot[gi] = (dig_d == 2'(gi));
    end
  endgenerate

  // mode bit 2 lights every point; otherwise bits 1:0 pick one digit.
  assign dp_hi = mode_sh_d[2] || (dig_d == mode_sh_d[1:0]);

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = DP_OFF;
    if (en_i) begin
      an_d  = AN_ACTIVE_LOW  ? ~an_hot : an_hot;
      seg_d = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
      dp_d  = SEG_ACTIVE_LOW ? ~dp_hi  : dp_hi;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      dig_q     <= 2'd0;
      shadow_q  <= 16'h0000;
      mode_sh_q <= 3'd0;
      frame_q   <= 1'b0;
      an_q      <= AN_OFF;
      seg_q     <= SEG_OFF;
      dp_q      <= DP_OFF;
    end else begin
      cnt_q     <= cnt_d;
      dig_q     <= dig_d;
      shadow_q  <= shadow_d;
      mode_sh_q <= mode_sh_d;
      frame_q   <= frame_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign an_o    = an_q;
  assign seg_o   = seg_q;
  assign dp_o    = dp_q;
  assign frame_o = frame_q;

endmodule
